// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter
//   Shares one combinational FP add/sub datapath between two requesters
//   (req0: integer-pipe FADD/FSUB issue, req1: fused/accumulate sequencer).
//   A round-robin grant picks one operation at a time. Its operands are
//   registered onto DP_OP_A/DP_OP_B/DP_FUNC and held for DP_LAT cycles so the
//   datapath can be multicycle-constrained. DP_RESULT is then captured and
//   returned on a valid/ready response channel, tagged with the requester ID
//   and the destination tag.
//
// Ports
//   CLK, RST (sync, active-low), FLUSH (sync abort of the in-flight op)
//   REQx_VALID/REQx_READY/REQx_OP_A/REQx_OP_B/REQx_FUNC/REQx_TAG : requesters
//   DP_OP_A/DP_OP_B/DP_FUNC out, DP_RESULT in                   : datapath
//   RSP_VALID/RSP_READY/RSP_RESULT/RSP_TAG/RSP_ID                : response
//   BUSY : high whenever the block is not idle
module fp_addsub_arbiter #(
  parameter int unsigned DP_LAT = 1,  // legal range 1..15
  parameter int unsigned TAG_W  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [31:0]      REQ0_OP_A,
  input  logic [31:0]      REQ0_OP_B,
  input  logic [3:0]       REQ0_FUNC,
  input  logic [TAG_W-1:0] REQ0_TAG,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [31:0]      REQ1_OP_A,
  input  logic [31:0]      REQ1_OP_B,
  input  logic [3:0]       REQ1_FUNC,
  input  logic [TAG_W-1:0] REQ1_TAG,
  output logic [31:0]      DP_OP_A,
  output logic [31:0]      DP_OP_B,
  output logic [3:0]       DP_FUNC,
  input  logic [31:0]      DP_RESULT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_RESULT,
  output logic [TAG_W-1:0] RSP_TAG,
  output logic             RSP_ID,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(DP_LAT - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               last_q, last_d;   // requester served most recently
  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic [3:0]         dp_func_q, dp_func_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_id_q, rsp_id_d;
  logic               grant;
  logic               accept;

  always_comb begin
    // With both valid, the one not served last wins; otherwise the lone
    // valid requester wins (the value is irrelevant when neither is valid).
    grant  = (REQ0_VALID && REQ1_VALID) ? ~last_q : ~REQ0_VALID;
    accept = (state_q == IDLE) && !FLUSH && (REQ0_VALID || REQ1_VALID);
    REQ0_READY = accept && !grant;
    REQ1_READY = accept && grant;

    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_func_d    = dp_func_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dp_a_d    = grant ? REQ1_OP_A : REQ0_OP_A;
          dp_b_d    = grant ? REQ1_OP_B : REQ0_OP_B;
          dp_func_d = grant ? REQ1_FUNC : REQ0_FUNC;
          rsp_tag_d = grant ? REQ1_TAG  : REQ0_TAG;
          rsp_id_d  = grant;
          last_d    = grant;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (FLUSH) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            rsp_result_d = DP_RESULT;
            rsp_valid_d  = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        if (FLUSH || RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;  // so req0 wins the first contested grant
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_func_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_func_q    <= dp_func_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign DP_OP_A    = dp_a_q;
  assign DP_OP_B    = dp_b_q;
  assign DP_FUNC    = dp_func_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_TAG    = rsp_tag_q;
  assign RSP_ID     = rsp_id_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares the single combinational FP add/sub datapath between two requesters: req0 is the integer-pipe FADD/FSUB issue and req1 is the fused/accumulate sequencer.
- Arbitrates between the two with round-robin priority.
- Registers the winning operands onto the datapath inputs and holds them for DP_LAT cycles so the path can be multicycle-constrained.
- Captures the datapath result and returns it with a valid/ready handshake, tagged with requester ID and destination tag.

Parameters:
- DP_LAT, 1, cycles operands are held before DP_RESULT is sampled; legal range 1..15.
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- FLUSH  input  1  synchronous abort of the in-flight operation.
- REQ0_VALID  input  1  requester 0 has an operation.
- REQ0_READY  output  1  requester 0 accepted this cycle.
- REQ0_OP_A  input  32  operand A, IEEE-754 single precision.
- REQ0_OP_B  input  32  operand B, IEEE-754 single precision.
- REQ0_FUNC  input  4  FP ALU function code (FADD/FSUB encoding).
- REQ0_TAG  input  TAG_W  destination tag.
- REQ1_VALID, REQ1_READY, REQ1_OP_A, REQ1_OP_B, REQ1_FUNC, REQ1_TAG: same directions, widths and meanings for requester 1.
- DP_OP_A  output  32  registered operand A to the datapath.
- DP_OP_B  output  32  registered operand B to the datapath.
- DP_FUNC  output  4  registered function code to the datapath.
- DP_RESULT  input  32  datapath IEEE result.
- RSP_VALID  output  1  result available.
- RSP_READY  input  1  consumer takes the result.
- RSP_RESULT  output  32  captured result.
- RSP_TAG  output  TAG_W  tag of the completed operation.
- RSP_ID  output  1  requester that issued the operation.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=0 at an edge):
  - State goes to IDLE.
  - Every output register clears to 0: DP_*, RSP_*, BUSY.
  - The round-robin pointer selects req0 first.
  - The in-flight operation is discarded silently; no response is produced for it.
- States: IDLE, ISSUE, DONE. Only one operation is outstanding at a time.
- IDLE:
  - Grant = the single valid requester.
  - If both are valid, grant the requester not served last.
  - REQx_READY = (state==IDLE) & grant==x & REQx_VALID, combinational. At most one READY is high per cycle.
  - On an accept edge:
    - DP_OP_A, DP_OP_B, DP_FUNC load the winner's operands.
    - Tag and ID are latched; the pointer updates to the winner.
    - The counter clears to 0 and the state goes to ISSUE.
- ISSUE:
  - DP_* are held stable.
  - The counter increments each edge.
  - At the edge where counter==DP_LAT-1, DP_RESULT is captured into RSP_RESULT, RSP_VALID is set, and the state goes to DONE.
  - RSP_VALID therefore rises DP_LAT edges after the accept edge.
- DONE:
  - RSP_VALID, RSP_RESULT, RSP_TAG and RSP_ID are held stable until RSP_READY is sampled high.
  - On that edge: RSP_VALID clears and the state goes to IDLE.
  - A new accept is possible on the following cycle, so the minimum issue interval is DP_LAT+2 cycles.
  - No REQx_READY is asserted while in ISSUE or DONE.
- FLUSH:
  - FLUSH=1 in ISSUE or DONE: state goes to IDLE, RSP_VALID clears, and no response is produced.
  - FLUSH=1 in IDLE suppresses acceptance that cycle; all READY outputs are forced to 0.
  - RST has priority over FLUSH.
  - The round-robin pointer is unaffected by FLUSH.
- Simultaneous events:
  - RSP_READY in a cycle where RSP_VALID=0 is ignored.
  - A requester may drop VALID without being granted; no state is kept per request.
- DP_OP_A, DP_OP_B and DP_FUNC are not cleared after completion. They retain the last issued values to avoid datapath toggling.
- The arithmetic is entirely in the datapath. The block passes FUNC through unmodified and never inspects operand values.

Test Plan:
- DP_LAT=1. req0 issues OP_A=0x3F800000, OP_B=0x40000000, FADD, TAG=5; datapath returns 0x40400000.
  - READY0 is high for 1 cycle.
  - RSP_VALID rises 1 edge after the accept edge.
  - RSP_RESULT=0x40400000, RSP_TAG=5, RSP_ID=0.
- Both requesters are held valid continuously after reset.
  - Grants alternate 0,1,0,1.
  - Each response carries the correct ID/TAG.
  - The issue interval is 3 cycles with RSP_READY=1.
- DP_LAT=3. Issue, with DP_RESULT changing every cycle.
  - RSP_RESULT equals the value present on the third edge after accept.
  - DP_OP_A and DP_OP_B are stable throughout ISSUE.
- RSP_READY is held at 0 for 10 cycles in DONE.
  - The RSP_* outputs are stable.
  - BUSY=1, and neither REQ_READY asserts despite valid requests.
  - Releasing RSP_READY returns the block to IDLE.
- FLUSH asserted 1 cycle into ISSUE (DP_LAT=3).
  - No RSP_VALID is produced.
  - The next request is accepted on the following cycle.
- RST=0 asserted in DONE with RSP_VALID=1.
  - On the next edge, RSP_VALID=0 and BUSY=0.
  - With both requesters then valid, req0 is granted first.
